rob_commit: RTL and testbench
=============================

# rob_commit

Reorder buffer that allocates rename tags to decode, collects results from the common data bus (CDB), and retires entries strictly in program order toward the architectural register file. It drives the register file's commit port (index/value/tag) and the global misbranch flush. It is the producer side of the register file's commit and misbranch inputs, and the source of the tags decode writes into the rename table.

## Interface
- ROB_SIZE, 16: physical entries. Tag 0 means "no producer", so tags 1..ROB_SIZE-1 are usable, giving capacity ROB_SIZE-1.
- TAG_W, 4: tag width, equal to log2(ROB_SIZE).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes all state and outputs
- in_decode_valid  in  1  allocate one entry this cycle
- in_decode_rd  in  5  destination register; 0 means no write
- out_decode_reorder  out  TAG_W  tag the next allocation receives (comb.); 0 when full or flushing
- out_rob_full  out  1  allocation refused this cycle (comb.)
- in_query_tag1, in_query_tag2  in  TAG_W  operand tags from the register file
- out_query_ready1, out_query_ready2  out  1  operand result available (comb.)
- out_query_value1, out_query_value2  out  32  operand result value (comb.)
- in_cdb_valid  in  1  result broadcast
- in_cdb_reorder  in  TAG_W  producing entry
- in_cdb_value  in  32  result
- in_cdb_misbranch  in  1  entry was mispredicted
- in_cdb_target  in  32  correct PC for a mispredicted entry
- out_rob_index  out  5  commit destination; 0 means no write this cycle
- out_rob_value  out  32  commit value
- out_rob_reorder  out  TAG_W  tag of the committing entry
- out_misbranch  out  1  one-cycle flush pulse
- out_target_pc  out  32  redirect PC, valid while out_misbranch is high

## Operation
- Each entry holds: busy, ready, rd[5], value[32], misbranch, target[32].
- head and tail range 1..ROB_SIZE-1 and wrap from ROB_SIZE-1 to 1. count ranges 0..ROB_SIZE-1.
- full = (count == ROB_SIZE-1) or state == FLUSH.
- **Allocate** (rdy, in_decode_valid, !full):
  - entry[tail] is set busy=1, ready=0, rd=in_decode_rd, misbranch=0.
  - tail advances; count increments.
  - out_decode_reorder equals tail before the edge.
- **CDB write** (rdy, in_cdb_valid, tag≠0, entry busy):
  - sets ready=1, value, misbranch and target.
  - A CDB write to a non-busy entry or to tag 0 is ignored.
- **Query:**
  - Tag 0 returns ready=0, value=0.
  - If in_cdb_valid and in_cdb_reorder equals the query tag, return ready=1 with in_cdb_value (same-cycle bypass).
  - Otherwise return the entry's ready and value.
- **Commit** (state RUN, rdy, entry[head] busy and ready):
  - Register out_rob_index=rd, out_rob_value=value, out_rob_reorder=head.
  - Clear busy; advance head; decrement count.
  - Cycles with no commit register out_rob_index=0, out_rob_reorder=0.
- **FSM:**
  - RUN→FLUSH: a committing entry has misbranch=1. Its rd write still issues normally; out_target_pc is latched from the entry.
  - FLUSH (exactly one cycle): no commit, no allocation, CDB ignored. Next edge: out_misbranch=1, out_rob_index=0, all busy cleared, head=tail=1, count=0, state RUN.
  - out_misbranch falls at the following edge.
- A simultaneous allocate and commit in RUN leaves count unchanged. full is evaluated from the pre-edge count, so a full buffer refuses the allocation even while committing.

## Timing
- Reset values: all entries not busy; head=tail=1; count=0; state RUN; out_rob_index=0, out_rob_value=0, out_rob_reorder=0; out_misbranch=0; out_target_pc=0. Combinational outputs follow from this state (out_decode_reorder=1, out_rob_full=0).
- Reset asserted mid-operation discards everything immediately (asynchronous).
- Allocation to earliest commit: a CDB write at edge N makes the entry ready; the commit outputs appear at edge N+1 if the entry is head.
- CDB write to head and commit in the same edge does not happen: the entry becomes ready at that edge and commits at the next.
- Misbranch: commit outputs at edge N, FLUSH during N..N+1, out_misbranch high during N+1..N+2.
- rdy low: all registers hold, including commit outputs. A repeated commit write is idempotent at the register file.

## Test plan
- Reset, then allocate rd=5,6,7 → tags 1,2,3. CDB tag 2=0x22, then tag 1=0x11, then tag 3=0x33 → commits in order (5,0x11,1), (6,0x22,2), (7,0x33,3) on consecutive cycles.
- Allocate 15 entries → out_rob_full=1 and out_decode_reorder=0. Commit one, then allocate → the new tag is 1 (wrap-around).
- Query tag 4 in the same cycle as a CDB broadcast of 0xABCD on tag 4 → ready1=1, value1=0xABCD. Query tag 0 → ready=0, value=0.
- Branch at tag 2 with misbranch=1 and target 0x1000, younger entries 3..5 allocated → tag 2 commits, then out_misbranch pulses once with out_target_pc=0x1000. Next allocation gets tag 1 and tags 3..5 never commit.
- Hold rdy=0 for 3 cycles while CDB and decode inputs are active → no state change. Outputs hold their last value.
- Assert rst asynchronously mid-stream with 6 busy entries → all outputs return to their reset values before the next clock edge.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer that allocates rename tags, collects CDB results and retires in program order
module rob_commit #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_decode_valid,
    input  logic [4:0]       in_decode_rd,
    output logic [TAG_W-1:0] out_decode_reorder,
    output logic             out_rob_full,
    input  logic [TAG_W-1:0] in_query_tag1,
    input  logic [TAG_W-1:0] in_query_tag2,
    output logic             out_query_ready1,
    output logic             out_query_ready2,
    output logic [31:0]      out_query_value1,
    output logic [31:0]      out_query_value2,
    input  logic             in_cdb_valid,
    input  logic [TAG_W-1:0] in_cdb_reorder,
    input  logic [31:0]      in_cdb_value,
    input  logic             in_cdb_misbranch,
    input  logic [31:0]      in_cdb_target,
    output logic [4:0]       out_rob_index,
    output logic [31:0]      out_rob_value,
    output logic [TAG_W-1:0] out_rob_reorder,
    output logic             out_misbranch,
    output logic [31:0]      out_target_pc
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [TAG_W-1:0] LAST = TAG_W'(ROB_SIZE - 1);
    localparam logic [TAG_W-1:0] FIRST = TAG_W'(1);

    state_t              state;
    logic [ROB_SIZE-1:0] busy, ready, mis;
    logic [4:0]          rd     [ROB_SIZE];
    logic [31:0]         value  [ROB_SIZE];
    logic [31:0]         target [ROB_SIZE];
    logic [TAG_W-1:0]    head, tail, count;
    logic                full, alloc, commit, cdb_wr;

    // Tag 0 is reserved for "no producer", so pointers wrap from LAST back to 1
    function automatic logic [TAG_W-1:0] nxt(input logic [TAG_W-1:0] p);
        return (p == LAST) ? FIRST : p + FIRST;
    endfunction

    // Handshake qualifiers derived from the pre-edge state
    always_comb begin
        full   = (count == LAST) || (state == FLUSH);
        alloc  = rdy && in_decode_valid && !full;
        commit = rdy && (state == RUN) && busy[head] && ready[head];
        cdb_wr = rdy && (state == RUN) && in_cdb_valid && (in_cdb_reorder != '0) && busy[in_cdb_reorder];
    end

    // Allocation tag and operand lookup, with same-cycle CDB bypass
    always_comb begin
        out_rob_full       = full;
        out_decode_reorder = full ? '0 : tail;
        out_query_ready1   = (in_query_tag1 == '0) ? 1'b0 :
                             (in_cdb_valid && in_cdb_reorder == in_query_tag1) ? 1'b1 : ready[in_query_tag1];
        out_query_value1   = (in_query_tag1 == '0) ? '0 :
                             (in_cdb_valid && in_cdb_reorder == in_query_tag1) ? in_cdb_value : value[in_query_tag1];
        out_query_ready2   = (in_query_tag2 == '0) ? 1'b0 :
                             (in_cdb_valid && in_cdb_reorder == in_query_tag2) ? 1'b1 : ready[in_query_tag2];
        out_query_value2   = (in_query_tag2 == '0) ? '0 :
                             (in_cdb_valid && in_cdb_reorder == in_query_tag2) ? in_cdb_value : value[in_query_tag2];
    end

    // Entry storage, pointers, RUN/FLUSH state and registered commit outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            busy  <= '0;
            ready <= '0;
            mis   <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd[i]     <= '0;
                value[i]  <= '0;
                target[i] <= '0;
            end
            head            <= FIRST;
            tail            <= FIRST;
            count           <= '0;
            out_rob_index   <= '0;
            out_rob_value   <= '0;
            out_rob_reorder <= '0;
            out_misbranch   <= 1'b0;
            out_target_pc   <= '0;
        end else if (rdy) begin
            if (state == FLUSH) begin
                busy            <= '0;
                head            <= FIRST;
                tail            <= FIRST;
                count           <= '0;
                state           <= RUN;
                out_misbranch   <= 1'b1;
                out_rob_index   <= '0;
                out_rob_reorder <= '0;
            end else begin
                out_misbranch <= 1'b0;
                if (cdb_wr) begin
                    ready[in_cdb_reorder]  <= 1'b1;
                    value[in_cdb_reorder]  <= in_cdb_value;
                    mis[in_cdb_reorder]    <= in_cdb_misbranch;
                    target[in_cdb_reorder] <= in_cdb_target;
                end
                if (commit) begin
                    out_rob_index   <= rd[head];
                    out_rob_value   <= value[head];
                    out_rob_reorder <= head;
                    busy[head]      <= 1'b0;
                    head            <= nxt(head);
                    if (mis[head]) begin
                        state         <= FLUSH;
                        out_target_pc <= target[head];
                    end
                end else begin
                    out_rob_index   <= '0;
                    out_rob_reorder <= '0;
                end
                if (alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    rd[tail]    <= in_decode_rd;
                    mis[tail]   <= 1'b0;
                    tail        <= nxt(tail);
                end
                count <= count + TAG_W'(alloc) - TAG_W'(commit);
            end
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed self-checking bench for rob_commit
module tb_rob_commit;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_decode_valid;
    logic [4:0]  in_decode_rd;
    logic [3:0]  out_decode_reorder;
    logic        out_rob_full;
    logic [3:0]  in_query_tag1, in_query_tag2;
    logic        out_query_ready1, out_query_ready2;
    logic [31:0] out_query_value1, out_query_value2;
    logic        in_cdb_valid;
    logic [3:0]  in_cdb_reorder;
    logic [31:0] in_cdb_value;
    logic        in_cdb_misbranch;
    logic [31:0] in_cdb_target;
    logic [4:0]  out_rob_index;
    logic [31:0] out_rob_value;
    logic [3:0]  out_rob_reorder;
    logic        out_misbranch;
    logic [31:0] out_target_pc;
    int          total = 0;
    int          passed = 0;

    rob_commit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_decode_valid(in_decode_valid), .in_decode_rd(in_decode_rd),
        .out_decode_reorder(out_decode_reorder), .out_rob_full(out_rob_full),
        .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
        .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
        .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
        .in_cdb_valid(in_cdb_valid), .in_cdb_reorder(in_cdb_reorder),
        .in_cdb_value(in_cdb_value), .in_cdb_misbranch(in_cdb_misbranch),
        .in_cdb_target(in_cdb_target),
        .out_rob_index(out_rob_index), .out_rob_value(out_rob_value),
        .out_rob_reorder(out_rob_reorder), .out_misbranch(out_misbranch),
        .out_target_pc(out_target_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cdb(input logic v, input logic [3:0] t, input logic [31:0] val, input logic m, input logic [31:0] tgt);
        in_cdb_valid = v;
        in_cdb_reorder = t;
        in_cdb_value = val;
        in_cdb_misbranch = m;
        in_cdb_target = tgt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        in_decode_valid = 1'b0;
        in_decode_rd = '0;
        in_query_tag1 = '0;
        in_query_tag2 = '0;
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic commit_chk(input string tag, input logic [4:0] idx, input logic [31:0] val, input logic [3:0] t);
        check({tag, ".index"}, 32'(out_rob_index), 32'(idx));
        check({tag, ".value"}, out_rob_value, val);
        check({tag, ".reorder"}, 32'(out_rob_reorder), 32'(t));
    endtask

    initial begin
        do_reset();
        check("rst.reorder", 32'(out_decode_reorder), 32'd1);
        check("rst.full", 32'(out_rob_full), 32'd0);
        commit_chk("rst", 5'd0, 32'd0, 4'd0);
        check("rst.misbranch", 32'(out_misbranch), 32'd0);
        check("rst.target", out_target_pc, 32'd0);

        // In-order commit despite out-of-order results
        in_decode_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_decode_rd = 5'(5 + i);
            check("alloc.tag", 32'(out_decode_reorder), 32'(i + 1));
            tick();
        end
        in_decode_valid = 1'b0;
        cdb(1'b1, 4'd2, 32'h22, 1'b0, 32'd0);
        tick();
        cdb(1'b1, 4'd1, 32'h11, 1'b0, 32'd0);
        tick();
        cdb(1'b1, 4'd3, 32'h33, 1'b0, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        commit_chk("c1", 5'd5, 32'h11, 4'd1);
        tick();
        commit_chk("c2", 5'd6, 32'h22, 4'd2);
        tick();
        commit_chk("c3", 5'd7, 32'h33, 4'd3);
        tick();
        commit_chk("idle", 5'd0, 32'h33, 4'd0);

        // Fill, query bypass, commit-while-full, wrap-around
        do_reset();
        in_decode_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_decode_rd = 5'(i + 1);
            tick();
        end
        in_decode_valid = 1'b0;
        check("full.flag", 32'(out_rob_full), 32'd1);
        check("full.reorder", 32'(out_decode_reorder), 32'd0);
        in_query_tag1 = 4'd4;
        in_query_tag2 = 4'd0;
        cdb(1'b1, 4'd4, 32'hABCD, 1'b0, 32'd0);
        #1;
        check("q.byp.ready", 32'(out_query_ready1), 32'd1);
        check("q.byp.value", out_query_value1, 32'hABCD);
        check("q.tag0.ready", 32'(out_query_ready2), 32'd0);
        check("q.tag0.value", out_query_value2, 32'd0);
        in_query_tag2 = 4'd5;
        #1;
        check("q.notready", 32'(out_query_ready2), 32'd0);
        tick();
        cdb(1'b1, 4'd1, 32'h77, 1'b0, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        check("q.stored.ready", 32'(out_query_ready1), 32'd1);
        check("q.stored.value", out_query_value1, 32'hABCD);
        in_decode_valid = 1'b1;
        in_decode_rd = 5'd9;
        tick();
        commit_chk("wrapc", 5'd1, 32'h77, 4'd1);
        check("wrap.reorder", 32'(out_decode_reorder), 32'd1);
        check("wrap.full", 32'(out_rob_full), 32'd0);
        tick();
        in_decode_valid = 1'b0;
        check("refill.full", 32'(out_rob_full), 32'd1);
        check("refill.reorder", 32'(out_decode_reorder), 32'd0);

        // Misbranch at tag 2 flushes younger tags 3..5
        do_reset();
        in_query_tag1 = '0;
        in_query_tag2 = '0;
        in_decode_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_decode_rd = 5'(i + 1);
            tick();
        end
        in_decode_valid = 1'b0;
        cdb(1'b1, 4'd1, 32'h100, 1'b0, 32'd0);
        tick();
        cdb(1'b1, 4'd2, 32'h200, 1'b1, 32'h1000);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        commit_chk("mb.c1", 5'd1, 32'h100, 4'd1);
        tick();
        commit_chk("mb.c2", 5'd2, 32'h200, 4'd2);
        check("mb.c2.misbranch", 32'(out_misbranch), 32'd0);
        check("flush.full", 32'(out_rob_full), 32'd1);
        check("flush.reorder", 32'(out_decode_reorder), 32'd0);
        cdb(1'b1, 4'd3, 32'h333, 1'b0, 32'd0);
        tick();
        check("mb.pulse", 32'(out_misbranch), 32'd1);
        check("mb.target", out_target_pc, 32'h1000);
        check("mb.index", 32'(out_rob_index), 32'd0);
        check("mb.newtag", 32'(out_decode_reorder), 32'd1);
        check("mb.full", 32'(out_rob_full), 32'd0);
        tick();
        check("mb.fall", 32'(out_misbranch), 32'd0);
        check("mb.nocommit1", 32'(out_rob_index), 32'd0);
        tick();
        check("mb.nocommit2", 32'(out_rob_reorder), 32'd0);
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);

        // rdy low freezes state and outputs
        in_decode_valid = 1'b1;
        in_decode_rd = 5'd8;
        tick();
        in_decode_rd = 5'd9;
        cdb(1'b1, 4'd1, 32'h55, 1'b0, 32'd0);
        tick();
        in_decode_valid = 1'b0;
        cdb(1'b1, 4'd2, 32'h66, 1'b0, 32'd0);
        tick();
        commit_chk("pre.hold", 5'd8, 32'h55, 4'd1);
        rdy = 1'b0;
        in_decode_valid = 1'b1;
        in_decode_rd = 5'd3;
        cdb(1'b1, 4'd2, 32'h99, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            commit_chk("hold", 5'd8, 32'h55, 4'd1);
            check("hold.reorder", 32'(out_decode_reorder), 32'd3);
        end
        rdy = 1'b1;
        in_decode_valid = 1'b0;
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        tick();
        commit_chk("post.hold", 5'd9, 32'h66, 4'd2);

        // Asynchronous reset with 6 busy entries
        do_reset();
        in_decode_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_decode_rd = 5'(i + 10);
            tick();
        end
        in_decode_valid = 1'b0;
        cdb(1'b1, 4'd1, 32'hAA, 1'b0, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        tick();
        commit_chk("pre.arst", 5'd10, 32'hAA, 4'd1);
        check("pre.arst.reorder", 32'(out_decode_reorder), 32'd8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        commit_chk("arst", 5'd0, 32'd0, 4'd0);
        check("arst.reorder", 32'(out_decode_reorder), 32'd1);
        check("arst.full", 32'(out_rob_full), 32'd0);
        check("arst.misbranch", 32'(out_misbranch), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("arst.after", 32'(out_rob_index), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
